// File: rtl/programm_lader.sv
// programm_lader -- byte-stream boot loader for the instruction RAM.
//
// Collects incoming bytes into WORDSIZE-bit words and writes each word into
// the RAM using a 4-phase request/acknowledge handshake. The CPU is held in
// reset until the complete image has been written, then released.
//
// Ports:
//   Clock          system clock, all state changes on posedge
//   Reset          synchronous, active-low reset
//   Start          begin a load session (ignored while Belegt)
//   WortAnzahl     number of words to load, sampled together with Start
//   ByteDaten      stream byte
//   ByteGueltig    ByteDaten valid
//   ByteBereit     loader accepts a byte (transfer = ByteGueltig & ByteBereit)
//   RAMAdresse     RAM write address
//   RAMDaten       RAM write data
//   RAMSchreiben   RAM write request
//   RAMGeschrieben RAM write done
//   Belegt         session active; selects the loader side of the RAM mux
//   CPUReset       active-high reset to the CPU
//   Fertig         image loaded, CPU released
//   Fehler         requested word count exceeds RAM depth
//   Pruefsumme     XOR of all words written in this session
module programm_lader #(
  parameter int                      WORDSIZE        = 32,
  parameter int                      WORDS           = 256,
  parameter int                      ADRESSBREITE    = 32,
  parameter logic [ADRESSBREITE-1:0] BASISADRESSE    = '0,
  parameter bit                      ERSTES_BYTE_MSB = 1'b1
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    Start,
  input  logic [ADRESSBREITE-1:0] WortAnzahl,
  input  logic [7:0]              ByteDaten,
  input  logic                    ByteGueltig,
  output logic                    ByteBereit,
  output logic [ADRESSBREITE-1:0] RAMAdresse,
  output logic [WORDSIZE-1:0]     RAMDaten,
  output logic                    RAMSchreiben,
  input  logic                    RAMGeschrieben,
  output logic                    Belegt,
  output logic                    CPUReset,
  output logic                    Fertig,
  output logic                    Fehler,
  output logic [WORDSIZE-1:0]     Pruefsumme
);

  localparam int BYTES = WORDSIZE / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [2:0] {
    LEERLAUF,
    SAMMELN,
    SCHREIBEN,
    WARTEN,
    FERTIG,
    FEHLER
  } zustand_t;

  zustand_t                state, nextState;
  logic [BCW-1:0]          byteCnt;
  logic [ADRESSBREITE-1:0] wordCnt;
  logic [ADRESSBREITE-1:0] countLatch;
  logic [WORDSIZE-1:0]     wordBuf;
  logic [WORDSIZE-1:0]     mergedWord;
  logic                    idle;
  logic                    transfer;
  logic                    lastByte;
  logic                    tooMany;
  logic                    sessionStart;

  assign idle         = (state == LEERLAUF) || (state == FERTIG) || (state == FEHLER);
  assign transfer     = (state == SAMMELN) && ByteGueltig;
  assign lastByte     = (byteCnt == BCW'(BYTES - 1));
  // Widened compare so a WORDS value that does not fit ADRESSBREITE stays correct.
  assign tooMany      = 64'(WortAnzahl) > 64'(WORDS);
  assign sessionStart = idle && Start && (WortAnzahl != '0) && !tooMany;

  // State register
  always_ff @(posedge Clock) begin
    if (!Reset) state <= LEERLAUF;
    else        state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    unique case (state)
      LEERLAUF, FERTIG, FEHLER: begin
        if (Start) begin
          if (WortAnzahl == '0) nextState = FERTIG;
          else if (tooMany)     nextState = FEHLER;
          else                  nextState = SAMMELN;
        end
      end
      SAMMELN:   if (transfer && lastByte) nextState = SCHREIBEN;
      SCHREIBEN: if (RAMGeschrieben)       nextState = WARTEN;
      WARTEN: begin
        if (!RAMGeschrieben)
          nextState = (wordCnt == countLatch) ? FERTIG : SAMMELN;
      end
      default:   nextState = LEERLAUF;
    endcase
  end

  // Control outputs decoded from state
  always_comb begin
    ByteBereit   = 1'b0;
    RAMSchreiben = 1'b0;
    Belegt       = 1'b0;
    CPUReset     = 1'b1;
    Fertig       = 1'b0;
    Fehler       = 1'b0;
    unique case (state)
      SAMMELN:   begin ByteBereit = 1'b1;   Belegt = 1'b1; end
      SCHREIBEN: begin RAMSchreiben = 1'b1; Belegt = 1'b1; end
      WARTEN:    Belegt = 1'b1;
      FERTIG:    begin Fertig = 1'b1; CPUReset = 1'b0; end
      FEHLER:    Fehler = 1'b1;
      default:   ;
    endcase
  end

  // Place the incoming byte into the slot selected by the byte counter.
  always_comb begin
    mergedWord = wordBuf;
    for (int unsigned i = 0; i < BYTES; i++) begin
      if (byteCnt == BCW'(i)) begin
        if (ERSTES_BYTE_MSB) mergedWord[WORDSIZE-1-8*i -: 8] = ByteDaten;
        else                 mergedWord[8*i +: 8]            = ByteDaten;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      byteCnt    <= '0;
      wordCnt    <= '0;
      countLatch <= '0;
      wordBuf    <= '0;
      RAMDaten   <= '0;
      RAMAdresse <= BASISADRESSE;
      Pruefsumme <= '0;
    end else begin
      if (sessionStart) begin
        countLatch <= WortAnzahl;
        wordCnt    <= '0;
        byteCnt    <= '0;
        wordBuf    <= '0;
        RAMAdresse <= BASISADRESSE;
        Pruefsumme <= '0;
      end
      if (transfer) begin
        if (lastByte) begin
          RAMDaten <= mergedWord;
          wordBuf  <= '0;
          byteCnt  <= '0;
        end else begin
          wordBuf  <= mergedWord;
          byteCnt  <= byteCnt + BCW'(1);
        end
      end
      if ((state == SCHREIBEN) && RAMGeschrieben) begin
        Pruefsumme <= Pruefsumme ^ RAMDaten;
        RAMAdresse <= RAMAdresse + ADRESSBREITE'(1);
        wordCnt    <= wordCnt + ADRESSBREITE'(1);
      end
    end
  end

endmodule

// File: tb/tb_programm_lader.sv
module tb_programm_lader;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 32-bit, MSB-first instance
  logic        start32, bv32, bb32, wr32, ack32, bel32, cpu32, fer32, feh32;
  logic [31:0] anz32, addr32, data32, sum32;
  logic [7:0]  bd32;

  // 16-bit, LSB-first instance at base 0x10
  logic        start16, bv16, bb16, wr16, ack16, bel16, cpu16, fer16, feh16;
  logic [31:0] anz16, addr16;
  logic [15:0] data16, sum16;
  logic [7:0]  bd16;

  programm_lader dut32 (
    .Clock(clk), .Reset(rst), .Start(start32), .WortAnzahl(anz32),
    .ByteDaten(bd32), .ByteGueltig(bv32), .ByteBereit(bb32),
    .RAMAdresse(addr32), .RAMDaten(data32), .RAMSchreiben(wr32),
    .RAMGeschrieben(ack32), .Belegt(bel32), .CPUReset(cpu32),
    .Fertig(fer32), .Fehler(feh32), .Pruefsumme(sum32)
  );

  programm_lader #(
    .WORDSIZE(16), .WORDS(256), .ADRESSBREITE(32),
    .BASISADRESSE(32'h10), .ERSTES_BYTE_MSB(1'b0)
  ) dut16 (
    .Clock(clk), .Reset(rst), .Start(start16), .WortAnzahl(anz16),
    .ByteDaten(bd16), .ByteGueltig(bv16), .ByteBereit(bb16),
    .RAMAdresse(addr16), .RAMDaten(data16), .RAMSchreiben(wr16),
    .RAMGeschrieben(ack16), .Belegt(bel16), .CPUReset(cpu16),
    .Fertig(fer16), .Fehler(feh16), .Pruefsumme(sum16)
  );

  int nChecks = 0;
  int nErrors = 0;

  logic [63:0] exp32[$];   // {addr, data}
  logic [47:0] exp16[$];   // {addr, data}
  logic [31:0] mem32 [0:255];
  int          ackDelay = 1;

  logic [31:0] img [7] = '{32'h8040000F, 32'h00200000, 32'h10000001, 32'h30C00002,
                           32'h20300000, 32'h50000003, 32'hF0000000};
  logic [31:0] img2 [3] = '{32'h11223344, 32'hA5A55A5A, 32'hDEADBEEF};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM responder + scoreboard monitor for the 32-bit instance
  initial begin : mon32
    int          waitCnt;
    bit          seen;
    logic [31:0] hA, hD;
    logic [63:0] e;
    waitCnt = 0;
    seen    = 1'b0;
    ack32   = 1'b0;
    forever begin
      @(negedge clk);
      if (wr32 && !ack32) begin
        if (!seen) begin
          seen = 1'b1;
          hA   = addr32;
          hD   = data32;
          if (exp32.size() == 0) begin
            nChecks++;
            nErrors++;
            $display("FAIL unexpected_write32: got addr %h data %h expected no write", addr32, data32);
          end else begin
            e = exp32.pop_front();
            check("write32_addr", addr32, e[63:32]);
            check("write32_data", data32, e[31:0]);
          end
          mem32[addr32[7:0]] = data32;
        end else begin
          check("hold32_addr", addr32, hA);
          check("hold32_data", data32, hD);
        end
        waitCnt++;
        if (waitCnt >= ackDelay) ack32 = 1'b1;
      end else if (!wr32) begin
        ack32   = 1'b0;
        seen    = 1'b0;
        waitCnt = 0;
      end
    end
  end

  // RAM responder + scoreboard monitor for the 16-bit instance
  initial begin : mon16
    logic [47:0] e;
    ack16 = 1'b0;
    forever begin
      @(negedge clk);
      if (wr16 && !ack16) begin
        if (exp16.size() == 0) begin
          nChecks++;
          nErrors++;
          $display("FAIL unexpected_write16: got addr %h data %h expected no write", addr16, data16);
        end else begin
          e = exp16.pop_front();
          check("write16_addr", addr16, e[47:16]);
          check("write16_data", data16, e[15:0]);
        end
        ack16 = 1'b1;
      end else if (!wr16) begin
        ack16 = 1'b0;
      end
    end
  end

  task automatic startSession(input bit sel, input logic [31:0] n);
    @(negedge clk);
    if (sel) begin start16 = 1'b1; anz16 = n; end
    else     begin start32 = 1'b1; anz32 = n; end
    @(negedge clk);
    start16 = 1'b0;
    start32 = 1'b0;
  endtask

  task automatic sendByte(input bit sel, input logic [7:0] b, input int gap);
    int t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    if (sel) begin bv16 = 1'b1; bd16 = b; end
    else     begin bv32 = 1'b1; bd32 = b; end
    while (!(sel ? bb16 : bb32) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      nChecks++;
      nErrors++;
      $display("FAIL byte_accept_timeout: got ByteBereit 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    bv16 = 1'b0;
    bv32 = 1'b0;
  endtask

  task automatic waitFertig(input bit sel, input string name);
    int t = 0;
    while (!(sel ? fer16 : fer32) && t < 500) begin
      @(negedge clk);
      t++;
    end
    check(name, sel ? fer16 : fer32, 1);
  endtask

  task automatic checkReset32(input string tag);
    check({tag, "_cpureset"},   cpu32,  1);
    check({tag, "_belegt"},     bel32,  0);
    check({tag, "_fertig"},     fer32,  0);
    check({tag, "_fehler"},     feh32,  0);
    check({tag, "_schreiben"},  wr32,   0);
    check({tag, "_bereit"},     bb32,   0);
    check({tag, "_adresse"},    addr32, 32'h0);
    check({tag, "_daten"},      data32, 32'h0);
    check({tag, "_pruefsumme"}, sum32,  32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] w;
    rst = 1'b0;
    start32 = 1'b0; anz32 = '0; bd32 = '0; bv32 = 1'b0;
    start16 = 1'b0; anz16 = '0; bd16 = '0; bv16 = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkReset32("rst");
    check("rst16_adresse", addr16, 32'h10);
    check("rst16_cpureset", cpu16, 1);
    rst = 1'b1;

    // 1: seven-word image, MSB-first, ack after one cycle
    for (int i = 0; i < 7; i++) exp32.push_back({32'(i), img[i]});
    startSession(1'b0, 32'd7);
    check("t1_belegt", bel32, 1);
    check("t1_cpureset", cpu32, 1);
    for (int i = 0; i < 7; i++) begin
      w = img[i];
      for (int k = 0; k < 4; k++) begin
        sendByte(1'b0, w[31-8*k -: 8], 0);
        if (i == 0 && k == 3) begin
          check("t1_latency_schreiben", wr32, 1);
          check("t1_bereit_in_write", bb32, 0);
        end
      end
    end
    waitFertig(1'b0, "t1_fertig");
    check("t1_cpureset_low", cpu32, 0);
    check("t1_belegt_low", bel32, 0);
    check("t1_pruefsumme", sum32, 32'h2090000F);
    check("t1_adresse", addr32, 32'd7);
    for (int i = 0; i < 7; i++) check("t1_ram", mem32[i], img[i]);

    // 2: byte gaps and a 5-cycle RAM acknowledge
    ackDelay = 5;
    for (int i = 0; i < 3; i++) exp32.push_back({32'(i), img2[i]});
    startSession(1'b0, 32'd3);
    for (int i = 0; i < 3; i++) begin
      w = img2[i];
      for (int k = 0; k < 4; k++) sendByte(1'b0, w[31-8*k -: 8], (i + k) % 3);
    end
    waitFertig(1'b0, "t2_fertig");
    check("t2_pruefsumme", sum32, 32'h6A2AD7F1);
    check("t2_adresse", addr32, 32'd3);
    ackDelay = 1;

    // 3: count beyond RAM depth
    startSession(1'b0, 32'd257);
    check("t3_fehler", feh32, 1);
    check("t3_cpureset", cpu32, 1);
    check("t3_belegt", bel32, 0);
    check("t3_fertig", fer32, 0);
    bv32 = 1'b1;
    bd32 = 8'hAA;
    repeat (10) @(negedge clk);
    check("t3_bereit", bb32, 0);
    check("t3_fehler_held", feh32, 1);
    bv32 = 1'b0;

    // 4: zero-length image
    startSession(1'b0, 32'd0);
    check("t4_fertig", fer32, 1);
    check("t4_cpureset", cpu32, 0);
    check("t4_fehler", feh32, 0);
    check("t4_belegt", bel32, 0);
    repeat (5) @(negedge clk);

    // 5: reset after two bytes of the second word, then reload
    exp32.push_back({32'h0, 32'h01020304});
    startSession(1'b0, 32'd3);
    w = 32'h01020304;
    for (int k = 0; k < 4; k++) sendByte(1'b0, w[31-8*k -: 8], 0);
    sendByte(1'b0, 8'hAA, 0);
    sendByte(1'b0, 8'hBB, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkReset32("t5_rst");
    rst = 1'b1;
    exp32.push_back({32'h0, 32'hCAFEF00D});
    exp32.push_back({32'h1, 32'h0BADC0DE});
    startSession(1'b0, 32'd2);
    w = 32'hCAFEF00D;
    for (int k = 0; k < 4; k++) sendByte(1'b0, w[31-8*k -: 8], 0);
    w = 32'h0BADC0DE;
    for (int k = 0; k < 4; k++) sendByte(1'b0, w[31-8*k -: 8], 0);
    waitFertig(1'b0, "t5_fertig");
    check("t5_pruefsumme", sum32, 32'hC15330D3);
    check("t5_adresse", addr32, 32'd2);
    check("t5_ram0", mem32[0], 32'hCAFEF00D);
    check("t5_ram1", mem32[1], 32'h0BADC0DE);

    // 6: 16-bit words, LSB-first, base address 0x10
    exp16.push_back({32'h10, 16'h1234});
    startSession(1'b1, 32'd1);
    sendByte(1'b1, 8'h34, 0);
    sendByte(1'b1, 8'h12, 0);
    waitFertig(1'b1, "t6_fertig");
    check("t6_pruefsumme", sum16, 16'h1234);
    check("t6_adresse", addr16, 32'h11);
    check("t6_cpureset", cpu16, 0);

    repeat (3) @(negedge clk);
    check("sb32_empty", exp32.size(), 0);
    check("sb16_empty", exp16.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
